// File: rtl/register_file.sv
// register_file: architectural general-purpose register bank with one synchronous write port
// and two combinational read ports. Define REGFILE_BYPASS_EN to forward same-cycle write data.
module register_file #(
    parameter int unsigned N        = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned SP_INDEX = 29,
    parameter logic [31:0] SP_RESET = 32'h7FFF_EFFC,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          write_enable,
    input  logic [AW-1:0] write_register,
    input  logic [N-1:0]  write_data,
    input  logic [AW-1:0] read_register_1,
    input  logic [AW-1:0] read_register_2,
    output logic [N-1:0]  read_data_1,
    output logic [N-1:0]  read_data_2
);

    localparam logic [N-1:0] SP_RESET_N = N'(SP_RESET);

    logic [N-1:0]        regs_q [NUM_REGS];
    logic [N-1:0]        regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] word_we_s;
    logic [N-1:0]        rd1_s;
    logic [N-1:0]        rd2_s;

    // Per-word write enables; word 0 and out-of-range addresses never match, so those writes vanish.
    always_comb begin
        word_we_s = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            word_we_s[i] = write_enable & (write_register == AW'(i));
        end
    end

    // Next-state for each storage word.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = word_we_s[i] ? write_data : regs_q[i];
        end
        regs_d[0] = '0;
    end

    // Storage words; async reset clears all but the stack pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == SP_INDEX) ? SP_RESET_N : '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // AND-OR read muxes starting at word 1, so address 0 and out-of-range addresses read 0.
    always_comb begin
        rd1_s = '0;
        rd2_s = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            rd1_s = rd1_s | ({N{read_register_1 == AW'(i)}} & regs_q[i]);
            rd2_s = rd2_s | ({N{read_register_2 == AW'(i)}} & regs_q[i]);
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_hit_s;

    // A live write to a real word overrides the stored value on any port addressing it.
    always_comb begin
        fwd_hit_s   = reset & (|word_we_s);
        read_data_1 = (fwd_hit_s && (read_register_1 == write_register)) ? write_data : rd1_s;
        read_data_2 = (fwd_hit_s && (read_register_2 == write_register)) ? write_data : rd2_s;
    end
`else
    assign read_data_1 = rd1_s;
    assign read_data_2 = rd2_s;
`endif

endmodule
